// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access stage.
// Accepts a decoded load/store, drives a byte-enabled word bus through a
// req/ack handshake, and returns an extended load result or a fault.
module load_store_unit #(
    parameter int WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Wait counter value in the last ACCESS cycle that may still see an ack.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_next_s;

    logic        is_store_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;

    logic        accept_s;
    logic        funct3_ok_s;
    logic        aligned_s;
    logic        legal_s;
    logic [3:0]  be_s;
    logic [31:0] wd_s;

    logic        busy_next_s;
    logic        done_next_s;
    logic        fault_next_s;
    logic        req_next_s;
    logic        we_next_s;
    logic [31:0] rdata_next_s;

    // Pick the addressed byte/halfword lane and sign- or zero-extend it.
    function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  extract_load = {{24{b[7]}}, b};
            3'b001:  extract_load = {{16{h[15]}}, h};
            3'b010:  extract_load = d;
            3'b100:  extract_load = {24'd0, b};
            3'b101:  extract_load = {16'd0, h};
            default: extract_load = 32'd0;
        endcase
    endfunction

    assign accept_s = (state_r == IDLE) && start;

    // Decode the incoming request: legality, alignment, byte enables, store data.
    always_comb begin
        aligned_s = 1'b0;
        be_s      = 4'b0000;
        wd_s      = 32'd0;
        case (funct3[1:0])
            2'b00: begin
                aligned_s = 1'b1;
                be_s      = 4'b0001 << addr[1:0];
                wd_s      = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned_s = ~addr[0];
                be_s      = addr[1] ? 4'b1100 : 4'b0011;
                wd_s      = {2{wdata[15:0]}};
            end
            2'b10: begin
                aligned_s = (addr[1:0] == 2'b00);
                be_s      = 4'b1111;
                wd_s      = wdata;
            end
            default: begin
                aligned_s = 1'b0;
                be_s      = 4'b0000;
                wd_s      = 32'd0;
            end
        endcase
        if (is_store) begin
            funct3_ok_s = funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            funct3_ok_s = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            wd_s        = 32'd0;
        end
        legal_s = funct3_ok_s && aligned_s;
    end

    // Next-state and next-output logic of the access FSM.
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        busy_next_s     = busy;
        done_next_s     = 1'b0;
        fault_next_s    = 1'b0;
        req_next_s      = mem_req;
        rdata_next_s    = rdata;
        case (state_r)
            IDLE: begin
                if (start) begin
                    busy_next_s     = 1'b1;
                    rdata_next_s    = 32'd0;
                    wait_cnt_next_s = 8'd0;
                    if (legal_s) begin
                        state_next_s = ACCESS;
                        req_next_s   = 1'b1;
                    end else begin
                        state_next_s = RESP;
                        req_next_s   = 1'b0;
                        done_next_s  = 1'b1;
                        fault_next_s = 1'b1;
                    end
                end else begin
                    busy_next_s = 1'b0;
                    req_next_s  = 1'b0;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    // Ack is checked first so it wins in the final permitted cycle.
                    state_next_s = RESP;
                    req_next_s   = 1'b0;
                    done_next_s  = 1'b1;
                    rdata_next_s = is_store_r ? 32'd0
                                              : extract_load(funct3_r, off_r, mem_rdata);
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = RESP;
                    req_next_s   = 1'b0;
                    done_next_s  = 1'b1;
                    fault_next_s = 1'b1;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + 8'd1;
                end
            end
            RESP: begin
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
                req_next_s   = 1'b0;
            end
            default: begin
                state_next_s    = IDLE;
                wait_cnt_next_s = 8'd0;
                busy_next_s     = 1'b0;
                req_next_s      = 1'b0;
            end
        endcase
        we_next_s = req_next_s && ((state_r == IDLE) ? is_store : is_store_r);
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Registered status, handshake and load-result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            fault   <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            busy    <= busy_next_s;
            done    <= done_next_s;
            fault   <= fault_next_s;
            mem_req <= req_next_s;
            mem_we  <= we_next_s;
            rdata   <= rdata_next_s;
        end
    end

    // Capture the request on acceptance; illegal requests leave the bus lines at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_store_r <= 1'b0;
            funct3_r   <= 3'd0;
            off_r      <= 2'd0;
            mem_addr   <= 32'd0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'd0;
        end else if (accept_s) begin
            is_store_r <= is_store;
            funct3_r   <= funct3;
            off_r      <= addr[1:0];
            mem_addr   <= legal_s ? {addr[31:2], 2'b00} : 32'd0;
            mem_be     <= legal_s ? be_s : 4'b0000;
            mem_wdata  <= legal_s ? wd_s : 32'd0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit (WAIT_MAX = 4).
module tb_load_store_unit;

    localparam int WMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    load_store_unit #(.WAIT_MAX(WMAX)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .fault(fault), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access: ack_at = req cycle in which ack is driven (0 = never),
    // poke_at = cycle in which a spurious start is pulsed (0 = none).
    task automatic run_access(input string name, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input int ack_at, input int poke_at,
                              input logic [3:0] ebe, input logic [31:0] ewd,
                              input logic [31:0] erd, input logic efault,
                              input int elat, input int ereq);
        exp_t e;
        exp_t got;
        int   req_cnt;
        bit   seen;
        logic [31:0] eaddr;
        eaddr    = a & 32'hFFFF_FFFC;
        start    = 1'b1;
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        e.rdata  = erd;
        e.fault  = efault;
        e.lat    = elat;
        sb.push_back(e);
        req_cnt  = 0;
        seen     = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start   = (c == poke_at) ? 1'b1 : 1'b0;
            if (c == poke_at) begin
                is_store = 1'b1;
                addr     = 32'h0000_0100;
            end
            mem_ack   = 1'b0;
            mem_rdata = 32'd0;
            check({name, ".busy"}, {31'd0, busy}, 32'd1);
            if (mem_req) begin
                req_cnt++;
                check({name, ".mem_addr"}, mem_addr, eaddr);
                check({name, ".mem_be"}, {28'd0, mem_be}, {28'd0, ebe});
                check({name, ".mem_we"}, {31'd0, mem_we}, {31'd0, st});
                check({name, ".mem_wdata"}, mem_wdata, ewd);
                if (req_cnt == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
            end
            if (done) begin
                got = sb.pop_front();
                check({name, ".latency"}, c, got.lat);
                check({name, ".fault"}, {31'd0, fault}, {31'd0, got.fault});
                check({name, ".rdata"}, rdata, got.rdata);
                check({name, ".req_cycles"}, req_cnt, ereq);
                check({name, ".req_low_at_done"}, {31'd0, mem_req}, 32'd0);
                seen = 1'b1;
                break;
            end
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        if (!seen) begin
            check({name, ".done_seen"}, 32'd0, 32'd1);
            sb.delete();
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            check({name, ".idle_busy"}, {31'd0, busy}, 32'd0);
            check({name, ".idle_done"}, {31'd0, done}, 32'd0);
            check({name, ".idle_req"}, {31'd0, mem_req}, 32'd0);
            check({name, ".rdata_hold"}, rdata, erd);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        is_store  = 1'b0;
        funct3    = 3'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        tick();
        tick();
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.req", {31'd0, mem_req}, 32'd0);
        check("rst.be", {28'd0, mem_be}, 32'd0);
        check("rst.rdata", rdata, 32'd0);
        reset = 1'b0;
        tick();

        run_access("sw", 1'b1, 3'b010, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 4, 0,
                   4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 5, 4);
        run_access("lb", 1'b0, 3'b000, 32'h1000_0003, 32'h0, 32'h80FF_1234, 1, 0,
                   4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1);
        run_access("lbu", 1'b0, 3'b100, 32'h1000_0003, 32'h0, 32'h80FF_1234, 1, 0,
                   4'b1000, 32'h0, 32'h0000_0080, 1'b0, 2, 1);
        run_access("lb1", 1'b0, 3'b000, 32'h1000_0001, 32'h0, 32'h0000_7F00, 2, 0,
                   4'b0010, 32'h0, 32'h0000_007F, 1'b0, 3, 2);
        run_access("lh", 1'b0, 3'b001, 32'h1000_0002, 32'h0, 32'h9ABC_0000, 2, 0,
                   4'b1100, 32'h0, 32'hFFFF_9ABC, 1'b0, 3, 2);
        run_access("lhu", 1'b0, 3'b101, 32'h1000_0002, 32'h0, 32'h9ABC_0000, 1, 0,
                   4'b1100, 32'h0, 32'h0000_9ABC, 1'b0, 2, 1);
        run_access("sh", 1'b1, 3'b001, 32'h1000_0002, 32'h0000_5566, 32'h0, 1, 0,
                   4'b1100, 32'h5566_5566, 32'h0, 1'b0, 2, 1);
        run_access("sb", 1'b1, 3'b000, 32'h1000_0001, 32'h0000_00A5, 32'h0, 1, 0,
                   4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 2, 1);
        run_access("lw_mis", 1'b0, 3'b010, 32'h1000_0001, 32'h0, 32'h0, 1, 0,
                   4'b0000, 32'h0, 32'h0, 1'b1, 1, 0);
        run_access("ld_f3_011", 1'b0, 3'b011, 32'h1000_0000, 32'h0, 32'h0, 1, 0,
                   4'b0000, 32'h0, 32'h0, 1'b1, 1, 0);
        run_access("timeout", 1'b0, 3'b010, 32'h2000_0000, 32'h0, 32'h0, 0, 0,
                   4'b1111, 32'h0, 32'h0, 1'b1, WMAX + 1, WMAX);
        run_access("ack_last", 1'b0, 3'b010, 32'h2000_0004, 32'h0, 32'h1234_5678, WMAX, 0,
                   4'b1111, 32'h0, 32'h1234_5678, 1'b0, WMAX + 1, WMAX);
        run_access("busy_start", 1'b0, 3'b010, 32'h3000_0004, 32'h0, 32'hCAFE_F00D, 3, 2,
                   4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0, 4, 3);

        // Reset in the second ACCESS cycle, then a late ack.
        start    = 1'b1;
        is_store = 1'b0;
        funct3   = 3'b010;
        addr     = 32'h4000_0000;
        tick();
        start = 1'b0;
        check("rr.req_c1", {31'd0, mem_req}, 32'd1);
        tick();
        check("rr.req_c2", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr.busy", {31'd0, busy}, 32'd0);
        check("rr.done", {31'd0, done}, 32'd0);
        check("rr.fault", {31'd0, fault}, 32'd0);
        check("rr.req", {31'd0, mem_req}, 32'd0);
        check("rr.we", {31'd0, mem_we}, 32'd0);
        check("rr.addr", mem_addr, 32'd0);
        check("rr.be", {28'd0, mem_be}, 32'd0);
        check("rr.wdata", mem_wdata, 32'd0);
        check("rr.rdata", rdata, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_ack = 1'b0;
            check("rr.no_done", {31'd0, done}, 32'd0);
            check("rr.no_req", {31'd0, mem_req}, 32'd0);
            check("rr.rdata_zero", rdata, 32'd0);
        end
        check("sb.empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage sitting directly downstream of the instruction decoder and ALU. It receives a decoded load/store request (store flag, funct3, ALU-computed byte address, rs2 store data) and drives a word-wide, byte-enabled data-memory bus through a req/ack handshake. It returns a sign- or zero-extended load result to the register write-back mux, or reports a fault for misaligned, illegal or timed-out accesses.

## Interface
Parameters:
- WAIT_MAX, default 16: maximum cycles `mem_req` may stay high without `mem_ack` before the access is aborted (legal range 1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request strobe from the core; sampled only in IDLE
- is_store  in  1  1 = store (decoder `dmemwe`), 0 = load
- funct3  in  3  instr[14:12]; selects width and extension
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  high with `done` when the access failed (misaligned, illegal funct3, timeout)
- rdata  out  32  extended load result; valid from the `done` cycle, held until the next accepted `start`
- mem_req  out  1  bus request; held until ack or timeout
- mem_we  out  1  bus write enable
- mem_addr  out  32  word address: {addr[31:2], 2'b00}
- mem_be  out  4  byte enables; bit i = byte lane i (little-endian)
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  bus completion; read data valid in the same cycle
- mem_rdata  in  32  bus read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on `start` = 1, register is_store, funct3, addr[1:0], mem_addr, mem_be, mem_wdata.
  - Access is legal → ACCESS.
  - Otherwise → RESP with fault pending; the bus is never touched.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Alignment rules:
  - Byte accesses: any address.
  - Halfword accesses: addr[0] = 0.
  - Word accesses: addr[1:0] = 00.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Halfword: 4'b0011 when addr[1] = 0, 4'b1100 when addr[1] = 1.
  - Word: 4'b1111.
  - Loads drive the same enables as stores.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
  - Loads drive mem_wdata = 0.
- ACCESS:
  - mem_req = 1, mem_we = is_store; all bus outputs stable while mem_req is high.
  - On `mem_ack` = 1: capture the extracted load data → RESP, no fault.
  - Wait counter increments each ACCESS cycle without ack; after WAIT_MAX cycles with no ack → RESP with fault.
- Load extraction:
  - Select the byte or halfword lane indexed by addr[1:0] or addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Stores and faulted accesses leave rdata = 0.
- RESP: done = 1 and fault = pending flag for exactly one cycle → IDLE.
- `start` outside IDLE is ignored; no queueing.
- `mem_ack` outside ACCESS is ignored.

## Timing
- Reset (sync, on an edge with reset = 1) forces:
  - state = IDLE, wait counter = 0.
  - busy, done, fault, mem_req, mem_we = 0.
  - mem_be = 0, mem_addr, mem_wdata, rdata = 0.
- All outputs are registered.
- Legal access, `start` at edge 0:
  - mem_req high from cycle 1.
  - Ack in cycle k (k ≥ 1) → done in cycle k+1.
  - Minimum start-to-done latency is 2 cycles.
- Illegal or misaligned access: done and fault in cycle 1; mem_req stays 0 throughout.
- Timeout: mem_req is high for exactly WAIT_MAX cycles (1..WAIT_MAX) → done and fault in cycle WAIT_MAX+1; mem_req low in that cycle.
- Ack in the final permitted cycle counts as success (ack wins over timeout).
- Reset during ACCESS: mem_req is 0 in the cycle after the reset edge; a late ack is ignored and no done is issued.
- busy is high from cycle 1 through the done cycle; `start` may be accepted in the cycle after done.

## Test plan
- SW: addr = 0x1000_0008, wdata = 0xDEAD_BEEF, ack 3 cycles after req rises → mem_addr = 0x1000_0008, mem_be = 1111, mem_we = 1, mem_wdata = 0xDEAD_BEEF; done with fault = 0 one cycle after ack; rdata = 0.
- LB/LBU: addr = 0x...03, mem_rdata = 0x80FF_1234 with immediate ack → mem_be = 1000; LB rdata = 0xFFFF_FF80; LBU rdata = 0x0000_0080; start-to-done = 2 cycles.
- LH/LHU/SH: addr = 0x...02, mem_rdata = 0x9ABC_0000 → LH rdata = 0xFFFF_9ABC, LHU rdata = 0x0000_9ABC; SH wdata = 0x0000_5566 → be = 1100, mem_wdata = 0x5566_5566.
- Misaligned LW at 0x...01, and funct3 = 011 load → fault and done in cycle 1; mem_req never asserted.
- Timeout with WAIT_MAX = 4, no ack → mem_req high exactly 4 cycles, then done = fault = 1. Repeat with ack in the 4th req cycle → fault = 0.
- Reset asserted in the 2nd ACCESS cycle, then ack pulsed → all outputs 0 after the edge, no done. A `start` pulse while busy → no second access.
